// File: rtl/signal_conflict_monitor_pkg.sv
// ============================================================================
// Module : signal_conflict_monitor_pkg
// Brief  : Light codes, fault codes, FSM states and helpers for the monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package signal_conflict_monitor_pkg;

   localparam logic [1:0] RED     = 2'd0;
   localparam logic [1:0] YELLOW  = 2'd1;
   localparam logic [1:0] GREEN   = 2'd2;
   localparam logic [1:0] ILLEGAL = 2'd3;

   localparam logic [2:0] FC_NONE     = 3'd0;
   localparam logic [2:0] FC_CONFLICT = 3'd1;
   localparam logic [2:0] FC_ILLEGAL  = 3'd2;
   localparam logic [2:0] FC_TRANS    = 3'd3;
   localparam logic [2:0] FC_YELLOW   = 3'd4;
   localparam logic [2:0] FC_ALLRED   = 3'd5;

   localparam logic [2:0] LAMP_RED    = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b100;

   typedef logic [1:0] state_t;
   localparam state_t ST_INIT  = 2'd0;
   localparam state_t ST_RUN   = 2'd1;
   localparam state_t ST_FAULT = 2'd2;

   // Code 3 never reaches the lamps (it faults), so it falls back to red.
   function automatic logic [2:0] decode_lamp(input logic [1:0] code);
      case (code)
         YELLOW:  decode_lamp = LAMP_YELLOW;
         GREEN:   decode_lamp = LAMP_GREEN;
         default: decode_lamp = LAMP_RED;
      endcase
   endfunction

   function automatic logic [2:0] encode_fault(input logic conflict,
                                               input logic illegal,
                                               input logic trans,
                                               input logic short_y,
                                               input logic short_ar);
      if (conflict)      encode_fault = FC_CONFLICT;
      else if (illegal)  encode_fault = FC_ILLEGAL;
      else if (trans)    encode_fault = FC_TRANS;
      else if (short_y)  encode_fault = FC_YELLOW;
      else if (short_ar) encode_fault = FC_ALLRED;
      else               encode_fault = FC_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/signal_conflict_monitor_road_aspect_checker.sv
// ============================================================================
// Module : road_aspect_checker
// Brief  : Per-road sequence checker: previous code, yellow dwell counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module road_aspect_checker
   import signal_conflict_monitor_pkg::*;
#(
   parameter int MIN_YELLOW = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] i_code,
   input  logic       i_adopt,
   input  logic       i_active,
   output logic       o_illegal_code,
   output logic       o_illegal_trans,
   output logic       o_short_yellow,
   output logic       o_r2g
);

   localparam int              c_YW   = $clog2(MIN_YELLOW + 1);
   localparam logic [c_YW-1:0] c_YMAX = c_YW'(MIN_YELLOW);
   localparam logic [c_YW-1:0] c_YONE = c_YW'(1);

   logic [1:0]      prev_q, prev_d;
   logic [c_YW-1:0] ycnt_q, ycnt_d;
   logic            w_hold;
   logic            w_step_ok;

   always_comb begin
      w_hold    = (i_code == prev_q);
      w_step_ok = (prev_q == GREEN  && i_code == YELLOW) ||
                  (prev_q == YELLOW && i_code == RED)    ||
                  (prev_q == RED    && i_code == GREEN);

      o_illegal_code  = (i_code == ILLEGAL);
      o_illegal_trans = !w_hold && !w_step_ok;
      o_short_yellow  = (prev_q == YELLOW) && (i_code == RED) && (ycnt_q < c_YMAX);
      o_r2g           = (prev_q == RED) && (i_code == GREEN);

      prev_d = prev_q;
      ycnt_d = ycnt_q;
      if (i_adopt) begin
         prev_d = i_code;
         ycnt_d = (i_code == YELLOW) ? c_YONE : '0;
      end else if (i_active) begin
         prev_d = i_code;
         if (i_code != YELLOW)
            ycnt_d = '0;
         else if (prev_q != YELLOW)
            ycnt_d = c_YONE;
         else if (ycnt_q < c_YMAX)
            ycnt_d = ycnt_q + c_YONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= RED;
         ycnt_q <= '0;
      end else begin
         prev_q <= prev_d;
         ycnt_q <= ycnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/signal_conflict_monitor.sv
// ============================================================================
// Module : signal_conflict_monitor
// Brief  : Decodes junction light codes to lamps and latches safety faults,
//          flashing both reds until reset.
//          Optional macro SIGNAL_MONITOR_FAULT_CLR_EN adds a fault_clr input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module signal_conflict_monitor
   import signal_conflict_monitor_pkg::*;
#(
   parameter int MIN_YELLOW = 3,
   parameter int MIN_ALLRED = 2,
   parameter int FLASH_DIV  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] hi_way,
   input  logic [1:0] cnt_way,
`ifdef SIGNAL_MONITOR_FAULT_CLR_EN
   input  logic       fault_clr,
`endif
   output logic [2:0] hi_lamp,
   output logic [2:0] cnt_lamp,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam int              c_AW   = $clog2(MIN_ALLRED + 1);
   localparam logic [c_AW-1:0] c_AMAX = c_AW'(MIN_ALLRED);
   localparam logic [c_AW-1:0] c_AONE = c_AW'(1);
   localparam int              c_FW   = $clog2(FLASH_DIV + 1);
   localparam logic [c_FW-1:0] c_FEND = c_FW'(FLASH_DIV - 1);
   localparam logic [c_FW-1:0] c_FONE = c_FW'(1);

   state_t          state_q, state_d;
   logic [c_AW-1:0] allred_q, allred_d;
   logic [c_FW-1:0] flash_cnt_q, flash_cnt_d;
   logic            flash_on_q, flash_on_d;
   logic [2:0]      hi_lamp_q, hi_lamp_d;
   logic [2:0]      cnt_lamp_q, cnt_lamp_d;
   logic            fault_q, fault_d;
   logic [2:0]      fault_code_q, fault_code_d;

   logic       w_clr;
   logic       w_is_init, w_is_run;
   logic       w_hi_ill, w_hi_trans, w_hi_sy, w_hi_r2g;
   logic       w_cnt_ill, w_cnt_trans, w_cnt_sy, w_cnt_r2g;
   logic       w_conflict, w_short_ar;
   logic [2:0] w_cause;

`ifdef SIGNAL_MONITOR_FAULT_CLR_EN
   assign w_clr = fault_clr;
`else
   assign w_clr = 1'b0;
`endif

   assign w_is_init = (state_q == ST_INIT);
   assign w_is_run  = (state_q == ST_RUN);

   road_aspect_checker #(.MIN_YELLOW(MIN_YELLOW)) u_hi_chk (
      .clk             (clk),
      .reset           (reset),
      .i_code          (hi_way),
      .i_adopt         (w_is_init),
      .i_active        (w_is_run),
      .o_illegal_code  (w_hi_ill),
      .o_illegal_trans (w_hi_trans),
      .o_short_yellow  (w_hi_sy),
      .o_r2g           (w_hi_r2g)
   );

   road_aspect_checker #(.MIN_YELLOW(MIN_YELLOW)) u_cnt_chk (
      .clk             (clk),
      .reset           (reset),
      .i_code          (cnt_way),
      .i_adopt         (w_is_init),
      .i_active        (w_is_run),
      .o_illegal_code  (w_cnt_ill),
      .o_illegal_trans (w_cnt_trans),
      .o_short_yellow  (w_cnt_sy),
      .o_r2g           (w_cnt_r2g)
   );

   always_comb begin
      w_conflict = (hi_way == YELLOW || hi_way == GREEN) &&
                   (cnt_way == YELLOW || cnt_way == GREEN);
      // allred_q counts consecutive both-red samples up to the previous cycle.
      w_short_ar = (w_hi_r2g || w_cnt_r2g) && (allred_q < c_AMAX);

      if (w_is_init)
         w_cause = encode_fault(w_conflict, w_hi_ill || w_cnt_ill, 1'b0, 1'b0, 1'b0);
      else
         w_cause = encode_fault(w_conflict, w_hi_ill || w_cnt_ill,
                                w_hi_trans || w_cnt_trans,
                                w_hi_sy || w_cnt_sy, w_short_ar);

      state_d      = state_q;
      allred_d     = allred_q;
      flash_cnt_d  = flash_cnt_q;
      flash_on_d   = flash_on_q;
      hi_lamp_d    = hi_lamp_q;
      cnt_lamp_d   = cnt_lamp_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;

      case (state_q)
         ST_INIT, ST_RUN: begin
            if (w_cause != FC_NONE) begin
               state_d      = ST_FAULT;
               fault_d      = 1'b1;
               fault_code_d = w_cause;
               flash_cnt_d  = '0;
               flash_on_d   = 1'b1;
               hi_lamp_d    = LAMP_RED;
               cnt_lamp_d   = LAMP_RED;
            end else begin
               state_d    = ST_RUN;
               hi_lamp_d  = decode_lamp(hi_way);
               cnt_lamp_d = decode_lamp(cnt_way);
               if (w_is_init)
                  allred_d = c_AMAX;
               else if (hi_way == RED && cnt_way == RED)
                  allred_d = (allred_q < c_AMAX) ? allred_q + c_AONE : allred_q;
               else
                  allred_d = '0;
            end
         end
         ST_FAULT: begin
            if (w_clr) begin
               state_d      = ST_INIT;
               fault_d      = 1'b0;
               fault_code_d = FC_NONE;
               allred_d     = '0;
               flash_cnt_d  = '0;
               flash_on_d   = 1'b1;
               hi_lamp_d    = LAMP_RED;
               cnt_lamp_d   = LAMP_RED;
            end else begin
               if (flash_cnt_q == c_FEND) begin
                  flash_cnt_d = '0;
                  flash_on_d  = !flash_on_q;
               end else begin
                  flash_cnt_d = flash_cnt_q + c_FONE;
               end
               hi_lamp_d  = {2'b00, flash_on_d};
               cnt_lamp_d = {2'b00, flash_on_d};
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_INIT;
         allred_q     <= '0;
         flash_cnt_q  <= '0;
         flash_on_q   <= 1'b1;
         hi_lamp_q    <= LAMP_RED;
         cnt_lamp_q   <= LAMP_RED;
         fault_q      <= 1'b0;
         fault_code_q <= FC_NONE;
      end else begin
         state_q      <= state_d;
         allred_q     <= allred_d;
         flash_cnt_q  <= flash_cnt_d;
         flash_on_q   <= flash_on_d;
         hi_lamp_q    <= hi_lamp_d;
         cnt_lamp_q   <= cnt_lamp_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign hi_lamp    = hi_lamp_q;
   assign cnt_lamp   = cnt_lamp_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

`default_nettype wire

// File: doc/signal_conflict_monitor.md
Name: signal_conflict_monitor

Overview:
- Consumer end of the 2-bit light-code interface driven by the junction controller (hi_way/cnt_way). It decodes each road's code into one-hot lamp drives.
- Independently checks the controller's output stream for safety violations:
  - both roads showing a non-red aspect at once,
  - an illegal code,
  - an illegal aspect sequence,
  - a yellow that is too short,
  - too little all-red clearance before a green.
- On any violation it latches a fault and forces both roads to flashing red until reset.

Parameters:
- MIN_YELLOW, 3, minimum consecutive cycles a road must show yellow before red.
- MIN_ALLRED, 2, minimum consecutive both-red cycles before either road may go green.
- FLASH_DIV, 8, half-period of the fault-mode red flash, in clk cycles (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- hi_way  input  2  highway light code: 0=RED, 1=YELLOW, 2=GREEN, 3=illegal.
- cnt_way  input  2  country-road light code, same encoding.
- hi_lamp  output  3  highway lamp drive, one-hot {G,Y,R} = bits [2:0].
- cnt_lamp  output  3  country lamp drive, one-hot {G,Y,R}.
- fault  output  1  latched fault flag.
- fault_code  output  3  cause of the first fault; 0 = none.

Behaviour:
- Interface: one clock, synchronous active-high reset on port `reset`; clock port is `clk`. All outputs are registered. Lamp and fault outputs reflect the input pair presented one cycle earlier (latency 1).
- Reset values:
  - hi_lamp = 3'b001, cnt_lamp = 3'b001 (both red).
  - fault = 0, fault_code = 0.
  - FSM = INIT; all counters 0; flash phase = on.
- FSM states: INIT, RUN, FAULT.
- INIT (one cycle):
  - Adopts the current pair as the previous sample; performs no sequence checks.
  - Presets the all-red counter to MIN_ALLRED so the first green is legal.
  - Still checks conflict and illegal code; either goes to FAULT, otherwise goes to RUN.
- RUN, per cycle, each road's current code against its registered previous code:
  - Legal transitions: hold, G→Y, Y→R, R→G. Any other change is an illegal transition.
  - Yellow counter: reset to 1 on entry to Y; increments while Y is held; saturates at MIN_YELLOW. A Y→R with counter < MIN_YELLOW is a short yellow.
  - All-red counter: increments (saturating at MIN_ALLRED) while both previous codes are RED; cleared when either is non-red. An R→G with counter < MIN_ALLRED is a short all-red.
  - Conflict: both current codes non-red (1 or 2).
- fault_code priority when several violations occur in the same cycle:
  - 1 conflict
  - 2 illegal code (value 3)
  - 3 illegal transition
  - 4 short yellow
  - 5 short all-red
- Lamps in RUN: decode the current code to one-hot, registered.
- FAULT:
  - Entered on the edge after the offending input. fault = 1 and fault_code holds the first cause; later violations are ignored.
  - Green and yellow lamp bits are forced to 0.
  - Red bit toggles every FLASH_DIV cycles, starting on.
  - Only reset exits FAULT (or the optional clear).
- Reset mid-operation: returns to INIT on the next edge regardless of state; counters cleared.

Optional Feature:
- Macro: SIGNAL_MONITOR_FAULT_CLR_EN.
- Defined:
  - Adds input port `fault_clr` (1 bit).
  - When fault_clr is high for one cycle while in FAULT, the next state is INIT, fault and fault_code clear to 0, and the lamps return to solid red.
  - fault_clr is ignored in INIT and RUN.
  - reset takes priority over fault_clr.
- Undefined: the port is absent and the fault latches until reset.

Decomposition:
- Shared package holds:
  - light-code constants RED/YELLOW/GREEN;
  - fault-code constants FC_NONE..FC_ALLRED;
  - the FSM state typedef.
- One natural sub-module: `road_aspect_checker`, instantiated twice. Per road, it holds the previous code and the yellow counter, and it outputs the illegal-code, illegal-transition, short-yellow and R→G-event flags.
- Top level holds the conflict check, all-red counter, priority encoder, FSM, flash divider and lamp registers.

Test Plan:
- Legal cycle: reset, then hi=G/cnt=R ×5, hi=Y ×4, both R ×3, cnt=G ×5, cnt=Y ×4, both R ×3 → lamps track the codes with 1-cycle lag, fault stays 0.
- Conflict: in RUN, drive hi=G and cnt=Y together → next edge fault=1, fault_code=1, hi_lamp/cnt_lamp=001. After 8 cycles the red bit goes to 0; after 8 more it returns to 1.
- Short yellow: hi Y held 2 cycles then R (MIN_YELLOW=3) → fault_code=4. With Y held exactly 3 cycles → no fault.
- Short all-red and illegal transition:
  - Both R for 1 cycle, then cnt=G → fault_code=5.
  - Separately, hi G→R directly → fault_code=3.
  - Code 3 on cnt_way → fault_code=2.
- Priority and latching: in the same cycle hi=3 and cnt=G → fault_code=2. A subsequent conflict does not change fault_code. Asserting reset for 1 cycle → fault=0, lamps=001, state INIT.
- With SIGNAL_MONITOR_FAULT_CLR_EN: force a fault, then pulse fault_clr → next edge fault=0, fault_code=0, and a legal pair is accepted in RUN.
